// File: rtl/riscv_test_monitor_if.sv
// Instruction-fetch request bus snooped by the riscv-tests pass/fail monitor.
interface riscv_test_monitor_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;

    // Driver side: the core/memory pair that owns the fetch handshake
    modport master (
        output imem_req_valid,
        output imem_req_ready,
        output imem_req_addr
    );

    // Observer side: the monitor only ever listens to the handshake
    modport slave (
        input imem_req_valid,
        input imem_req_ready,
        input imem_req_addr
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout verdict monitor for riscv-tests runs on the Sodor tile.
// Snoops accepted fetch addresses and declares a verdict once the core keeps
// fetching the pass or fail handler, or declares a timeout when the RUN-cycle
// budget runs out first.
module riscv_test_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'h80000454,
    parameter logic [31:0] FAIL_ADDR      = 32'h80000438,
    parameter int          HIT_COUNT      = 2,
    parameter int          TIMEOUT_CYCLES = 600
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    riscv_test_monitor_if.slave         imem,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic                        o_fail,
    output logic                        o_timeout,
    output logic                        o_done_pulse,
    output logic [31:0]                 o_cycle_count,
    output logic [31:0]                 o_fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]  LP_HIT_COUNT    = 4'(HIT_COUNT);
    localparam logic [31:0] LP_LAST_CYCLE   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LP_FETCH_SATMAX = 32'hFFFFFFFF;

    state_t      r_state;
    state_t      w_nextState;

    logic [3:0]  r_hitCnt;
    logic        r_hitTgtFail;
    logic [31:0] r_cycleCount;
    logic [31:0] r_fetchCount;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic        r_donePulse;

    logic        w_accepted;
    logic        w_isFail;
    logic        w_isPass;
    logic        w_isTarget;
    logic        w_sameTarget;
    logic [3:0]  w_hitCntNext;
    logic        w_running;
    logic        w_verdict;
    logic        w_timeoutHit;
    logic        w_arm;

    // Fail address is decoded first so a pass/fail address collision reads as FAIL
    assign w_accepted   = imem.imem_req_valid & imem.imem_req_ready;
    assign w_isFail     = (imem.imem_req_addr == FAIL_ADDR);
    assign w_isPass     = (imem.imem_req_addr == PASS_ADDR) & ~w_isFail;
    assign w_isTarget   = w_isFail | w_isPass;
    assign w_sameTarget = (r_hitTgtFail == w_isFail);
    assign w_running    = (r_state == ST_RUN);
    assign w_arm        = i_start & ~w_running;

    // Next hit count: extend a streak on the same target, restart on the other, drop on anything else
    always_comb begin
        w_hitCntNext = r_hitCnt;
        if (w_accepted) begin
            if (w_isTarget) begin
                if (!w_sameTarget) begin
                    w_hitCntNext = 4'd1;
                end else if (r_hitCnt >= LP_HIT_COUNT) begin
                    w_hitCntNext = LP_HIT_COUNT;
                end else begin
                    w_hitCntNext = r_hitCnt + 4'd1;
                end
            end else begin
                w_hitCntNext = 4'd0;
            end
        end
    end

    // A verdict outranks a timeout landing on the same edge
    assign w_verdict    = w_running & w_accepted & w_isTarget & (w_hitCntNext == LP_HIT_COUNT);
    assign w_timeoutHit = w_running & (r_cycleCount == LP_LAST_CYCLE) & ~w_verdict;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start arms from IDLE/DONE, verdict or budget exhaustion ends RUN
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_nextState = ST_RUN;
            ST_RUN:  if (w_verdict || w_timeoutHit) w_nextState = ST_DONE;
            ST_DONE: if (i_start) w_nextState = ST_RUN;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output decode: status flags straight from the state register, the rest from registers
    always_comb begin
        o_busy        = (r_state == ST_RUN);
        o_done        = (r_state == ST_DONE);
        o_pass        = r_pass;
        o_fail        = r_fail;
        o_timeout     = r_timeout;
        o_done_pulse  = r_donePulse;
        o_cycle_count = r_cycleCount;
        o_fetch_count = r_fetchCount;
    end

    // Hit tracker: cleared on arm, only accepted fetches in RUN move it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hitCnt     <= 4'd0;
            r_hitTgtFail <= 1'b0;
        end else if (w_arm) begin
            r_hitCnt     <= 4'd0;
            r_hitTgtFail <= 1'b0;
        end else if (w_running && w_accepted) begin
            r_hitCnt <= w_hitCntNext;
            if (w_isTarget) begin
                r_hitTgtFail <= w_isFail;
            end
        end
    end

    // Counters: cycles tick every RUN edge, fetches saturate; both freeze outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycleCount <= 32'd0;
            r_fetchCount <= 32'd0;
        end else if (w_arm) begin
            r_cycleCount <= 32'd0;
            r_fetchCount <= 32'd0;
        end else if (w_running) begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (w_accepted && (r_fetchCount != LP_FETCH_SATMAX)) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
        end
    end

    // Sticky verdict bits plus the one-cycle strobe marking entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_donePulse <= 1'b0;
        end else begin
            r_donePulse <= w_verdict | w_timeoutHit;
            if (w_arm) begin
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_verdict) begin
                r_pass <= w_isPass;
                r_fail <= w_isFail;
            end else if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule
